calc1_port_resp: RTL and testbench
==================================

# calc1_port_resp

Single-port responder for the calc1 request/response protocol: the target end of one `reqN_cmd_in`/`reqN_data_in`/`out_respN`/`out_dataN` channel. It captures a command with two operands, runs the add/sub/shift operation after a programmable delay, and returns a one-cycle response code with its result. Four instances plus an arbiter-free top make a calc1-compatible array; one instance alone is the unit the port-level benches drive.

## Interface
- `LATENCY`, 3: cycles from operand-2 sample edge to response cycle; legal 1..15.
- `c_clk`  in  1  clock; all sampling on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `req_cmd_in`  in  [0:3]  command; 0 = no request.
- `req_data_in`  in  [0:31]  operand 1 in the command cycle, operand 2 in the following cycle.
- `out_resp`  out  [0:1]  0 none, 1 success, 2 overflow/underflow, 3 invalid command.
- `out_data`  out  [0:31]  result; valid only when `out_resp` != 0, else 0.

## Operation
- Bit 0 is MSB on all buses; arithmetic is 32-bit unsigned.
- Commands: 1 add, 2 subtract, 5 shift left logical, 6 shift right logical; any other nonzero value is invalid.
- FSM: IDLE -> OPND2 -> EXEC -> RESP -> IDLE.
  - IDLE: edge with `req_cmd_in` != 0 latches cmd and operand 1, go OPND2.
  - OPND2: next edge latches `req_data_in` as operand 2 unconditionally (`req_cmd_in` ignored), computes result/flag, loads delay counter, go EXEC.
  - EXEC: counter decrements; on expiry go RESP.
  - RESP: drive response one cycle. A nonzero `req_cmd_in` at the edge leaving RESP is accepted (go OPND2); otherwise go IDLE.
- Add: carry out of bit 0 -> resp 2, data 0; else resp 1, data = sum.
- Subtract (op1 - op2): op2 > op1 -> resp 2, data 0; equal gives resp 1, data 0.
- Shifts: amount = op2[27:31]; op2[0:26] ignored; never overflows; amount 0 returns op1.
- Invalid command: still consumes the operand-2 cycle and LATENCY; resp 3, data 0.
- Commands in OPND2 or EXEC are ignored: no response, no state change.
- Reset mid-operation: in-flight request discarded, no response emitted afterwards.

## Timing
- Reset values: `out_resp` = 0, `out_data` = 0, FSM IDLE, counter 0.
- Command sampled at edge E0, operand 2 at E1; `out_resp`/`out_data` registered, nonzero in the cycle after edge E1+LATENCY, back to 0 after edge E1+LATENCY+1.
- Minimum request spacing: LATENCY+2 cycles (command may be presented during the response cycle).
- Outputs change only on clock edges or asynchronous reset assertion; no combinational input-to-output path.

## Structure
- Package `calc1_pkg`: command codes (`CMD_NOP`, `CMD_ADD`, `CMD_SUB`, `CMD_SHL`, `CMD_SHR`), response codes (`RESP_NONE`, `RESP_OK`, `RESP_OVF`, `RESP_INV`), data/cmd/resp widths, FSM state encoding.
- Sub-module `calc1_alu`: combinational, inputs cmd/op1/op2, outputs 32-bit result and 2-bit resp code; shared with the future four-port top.
- Responder holds FSM, operand/result registers, 4-bit delay counter.

## Test plan
- Reset held 4 cycles, released -> `out_resp` = 0, `out_data` = 0; cmd 1, op 0000_0001h then 1FFF_FFFFh -> resp 1, data 2000_0000h exactly LATENCY+1 cycles after operand-2 edge, one cycle wide.
- Add FFFF_FFFFh + 0000_0001h -> resp 2, data 0; add 1FFF_FFFFh + 1FFF_FFFFh -> resp 1, data 3FFF_FFFEh.
- Sub 5 - 5 -> resp 1, data 0; sub 4 - 5 -> resp 2, data 0.
- Shl 0000_0001h by FFFF_FFFFh (amount 31) -> resp 1, data 8000_0000h; shr 8000_0000h by 4 -> resp 1, data 0800_0000h.
- Cmd 3, ops 7, 7 -> resp 3, data 0; cmd 1 issued again during EXEC -> ignored, exactly one response.
- Reset asserted mid-EXEC of add 1+1 -> outputs 0 immediately, no response after release; new cmd 1 with 2 + 3 pipelined into the RESP cycle of a prior request -> back-to-back responses, second data 5.

Source files
------------

// File: rtl/calc1_pkg.sv
// calc1 protocol definitions shared by the port responder and the ALU:
// bus widths, command/response codes and the responder state encoding.
// All buses are declared [0:W-1] so bit 0 is the MSB, as on the wire.
`timescale 1ns/1ps
package calc1_pkg;

    localparam int DATA_W = 32;
    localparam int CMD_W  = 4;
    localparam int RESP_W = 2;

    typedef logic [0:DATA_W-1] data_t;
    typedef logic [0:CMD_W-1]  cmd_t;
    typedef logic [0:RESP_W-1] resp_t;

    localparam cmd_t CMD_NOP = 4'd0;
    localparam cmd_t CMD_ADD = 4'd1;
    localparam cmd_t CMD_SUB = 4'd2;
    localparam cmd_t CMD_SHL = 4'd5;
    localparam cmd_t CMD_SHR = 4'd6;

    localparam resp_t RESP_NONE = 2'd0;
    localparam resp_t RESP_OK   = 2'd1;
    localparam resp_t RESP_OVF  = 2'd2;
    localparam resp_t RESP_INV  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPND2 = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/calc1_alu.sv
// Combinational calc1 operation unit: add/sub/shift on 32-bit unsigned
// operands. Produces the response code alongside the result; the result is
// forced to zero whenever the code is not success, so callers can register
// both outputs without further masking.
`timescale 1ns/1ps
module calc1_alu
    import calc1_pkg::*;
(
    input  cmd_t  cmd,
    input  data_t op1,
    input  data_t op2,
    output data_t result,
    output resp_t resp
);

    // Extra top bit captures the carry out of the operand MSB.
    logic [DATA_W:0] sum_ext;
    // Only the five least significant bits of operand 2 select the shift.
    logic [4:0]      shamt;

    assign sum_ext = {1'b0, op1} + {1'b0, op2};
    assign shamt   = op2[27:31];

    // Select the operation and classify the outcome.
    always_comb begin
        result = '0;
        resp   = RESP_OK;
        case (cmd)
            CMD_ADD: begin
                if (sum_ext[DATA_W]) resp = RESP_OVF;
                else                 result = sum_ext[DATA_W-1:0];
            end
            CMD_SUB: begin
                if (op2 > op1) resp = RESP_OVF;
                else           result = op1 - op2;
            end
            CMD_SHL: result = op1 << shamt;
            CMD_SHR: result = op1 >> shamt;
            default: resp = RESP_INV;
        endcase
    end

endmodule

// File: rtl/calc1_port_resp.sv
// Single-port calc1 responder. Captures command + operand 1, then operand 2
// on the following edge (where the ALU result is registered), waits LATENCY
// edges and presents a one-cycle registered response. A new command may be
// accepted on the edge that ends the response cycle.
`timescale 1ns/1ps
module calc1_port_resp
    import calc1_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [0:CMD_W-1]  req_cmd_in,
    input  logic [0:DATA_W-1] req_data_in,
    output logic [0:RESP_W-1] out_resp,
    output logic [0:DATA_W-1] out_data
);

    // Counter is loaded with LATENCY-1 so that the edge on which it reads
    // zero is exactly LATENCY edges after the operand-2 edge.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t     state_reg;
    cmd_t       cmd_reg;
    data_t      op1_reg;
    data_t      result_reg;
    resp_t      flag_reg;
    logic [3:0] cnt_reg;

    data_t      alu_result;
    resp_t      alu_resp;

    // Operand 2 feeds the ALU straight from the bus; the result is only
    // captured on the operand-2 edge, so no input reaches the outputs
    // without passing through a register.
    calc1_alu u_alu (
        .cmd    (cmd_reg),
        .op1    (op1_reg),
        .op2    (req_data_in),
        .result (alu_result),
        .resp   (alu_resp)
    );

    // Request FSM with operand, result, delay counter and output registers.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cmd_reg    <= CMD_NOP;
            op1_reg    <= '0;
            result_reg <= '0;
            flag_reg   <= RESP_NONE;
            cnt_reg    <= '0;
            out_resp   <= RESP_NONE;
            out_data   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_cmd_in != CMD_NOP) begin
                        cmd_reg   <= req_cmd_in;
                        op1_reg   <= req_data_in;
                        state_reg <= ST_OPND2;
                    end
                end
                ST_OPND2: begin
                    result_reg <= alu_result;
                    flag_reg   <= alu_resp;
                    cnt_reg    <= CNT_LOAD;
                    state_reg  <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (cnt_reg == 4'd0) begin
                        out_resp  <= flag_reg;
                        out_data  <= result_reg;
                        state_reg <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_RESP: begin
                    out_resp <= RESP_NONE;
                    out_data <= '0;
                    if (req_cmd_in != CMD_NOP) begin
                        cmd_reg   <= req_cmd_in;
                        op1_reg   <= req_data_in;
                        state_reg <= ST_OPND2;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_port_resp.sv
// Bench for calc1_port_resp: directed cases with hand-computed results,
// then a long randomized run. A transaction-level model predicts, per clock
// edge, which response must appear; a compare process checks the outputs
// on every falling edge.
`timescale 1ns/1ps
module tb_calc1_port_resp;

    localparam int L = 3;

    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic [0:3]  req_cmd_in = '0;
    logic [0:31] req_data_in = '0;
    logic [0:1]  out_resp;
    logic [0:31] out_data;

    calc1_port_resp #(.LATENCY(L)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data)
    );

    initial forever #5 c_clk = ~c_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int          e;
        int unsigned r;
        int unsigned d;
    } exp_t;
    exp_t q[$];

    int          free_edge = 0;
    bit          pend = 1'b0;
    int unsigned p_cmd = 0;
    int unsigned p_op1 = 0;

    // Reference result of one calc1 operation from plain arithmetic.
    function automatic void ref_op(input int unsigned c, input int unsigned a,
                                   input int unsigned b, output int unsigned r,
                                   output int unsigned d);
        longint unsigned s;
        r = 1;
        d = 0;
        case (c)
            1: begin
                s = a;
                s = s + b;
                if (s > 64'hFFFF_FFFF) r = 2;
                else d = a + b;
            end
            2: begin
                if (b > a) r = 2;
                else d = a - b;
            end
            5: d = a << (b % 32);
            6: d = a >> (b % 32);
            default: r = 3;
        endcase
    endfunction

    task automatic check(input string name, input int unsigned got_r, input int unsigned exp_r,
                         input int unsigned got_d, input int unsigned exp_d);
        n_cmp++;
        if (got_r != exp_r || got_d != exp_d) begin
            n_bad++;
            $display("FAIL %s cycle=%0d: got resp=%0d data=%08h, want resp=%0d data=%08h",
                     name, cyc, got_r, got_d, exp_r, exp_d);
        end
    endtask

    // Model: a command is taken when the port is free; the next edge always
    // supplies operand 2 and fixes the response edge LATENCY edges later.
    // The port is free again on the edge that ends the response cycle.
    initial begin : model
        int unsigned r, d;
        forever begin
            @(posedge c_clk);
            cyc++;
            if (reset) begin
                q.delete();
                pend = 1'b0;
                free_edge = 0;
            end else if (pend) begin
                ref_op(p_cmd, p_op1, req_data_in, r, d);
                q.push_back('{cyc + L, r, d});
                pend = 1'b0;
            end else if (req_cmd_in != 0 && cyc >= free_edge) begin
                pend = 1'b1;
                p_cmd = 32'(req_cmd_in);
                p_op1 = req_data_in;
                free_edge = cyc + L + 2;
            end
        end
    end

    // Compare outputs with the model every cycle.
    initial begin : compare
        forever begin
            @(negedge c_clk);
            if (reset) begin
                q.delete();
                pend = 1'b0;
                free_edge = 0;
                check("reset_zero", 32'(out_resp), 0, out_data, 0);
            end else if (q.size() > 0 && q[0].e == cyc) begin
                check("resp", 32'(out_resp), q[0].r, out_data, q[0].d);
                void'(q.pop_front());
            end else begin
                check("idle_zero", 32'(out_resp), 0, out_data, 0);
            end
        end
    end

    task automatic drive(input int unsigned c, input int unsigned d);
        @(negedge c_clk);
        req_cmd_in = 4'(c);
        req_data_in = d;
    endtask

    // One isolated request with literal expectations at the response cycle.
    task automatic directed(input string name, input int unsigned c, input int unsigned a,
                            input int unsigned b, input int unsigned er, input int unsigned ed);
        int unsigned mr, md;
        ref_op(c, a, b, mr, md);
        check({name, "_model"}, mr, er, md, ed);
        drive(c, a);
        drive(0, b);
        repeat (L) drive(0, $urandom);
        @(negedge c_clk);
        check(name, 32'(out_resp), er, out_data, ed);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int cnt;
        int sel;
        int unsigned dv;

        reset = 1'b1;
        repeat (4) @(posedge c_clk);
        @(negedge c_clk);
        reset = 1'b0;
        @(negedge c_clk);
        check("post_reset", 32'(out_resp), 0, out_data, 0);

        directed("add_basic",  1, 32'h0000_0001, 32'h1FFF_FFFF, 1, 32'h2000_0000);
        directed("add_ovf",    1, 32'hFFFF_FFFF, 32'h0000_0001, 2, 0);
        directed("add_big",    1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 1, 32'h3FFF_FFFE);
        directed("sub_eq",     2, 5, 5, 1, 0);
        directed("sub_unf",    2, 4, 5, 2, 0);
        directed("shl_31",     5, 32'h0000_0001, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        directed("shr_4",      6, 32'h8000_0000, 4, 1, 32'h0800_0000);
        directed("shl_0",      5, 32'h1234_5678, 32'hFFFF_FFE0, 1, 32'h1234_5678);
        directed("inv_3",      3, 7, 7, 3, 0);
        directed("inv_15",     15, 9, 1, 3, 0);

        // Commands presented during EXEC must not start a second request.
        cnt = 0;
        drive(1, 2);
        drive(0, 3);
        drive(1, 100);
        drive(1, 200);
        drive(0, 0);
        repeat (6) begin
            @(negedge c_clk);
            if (out_resp != 0) cnt++;
        end
        n_cmp++;
        if (cnt != 1) begin
            n_bad++;
            $display("FAIL exec_ignore: got %0d responses, want 1", cnt);
        end

        // Reset during EXEC discards the request.
        drive(1, 1);
        drive(0, 1);
        @(posedge c_clk);
        @(posedge c_clk);
        #1 reset = 1'b1;
        #1 check("reset_exec", 32'(out_resp), 0, out_data, 0);
        repeat (2) @(negedge c_clk);
        reset = 1'b0;
        repeat (L + 4) drive(0, 0);

        // Reset during the response cycle clears outputs at once.
        drive(1, 6);
        drive(0, 7);
        repeat (L) drive(0, 0);
        @(negedge c_clk);
        check("resp_before_reset", 32'(out_resp), 1, out_data, 13);
        #1 reset = 1'b1;
        #1 check("reset_resp_clear", 32'(out_resp), 0, out_data, 0);
        @(negedge c_clk);
        reset = 1'b0;
        repeat (L + 3) drive(0, 0);

        // Back-to-back: second command presented in the response cycle.
        drive(1, 10);
        drive(0, 20);
        repeat (L) drive(0, 0);
        @(negedge c_clk);
        check("b2b_first", 32'(out_resp), 1, out_data, 30);
        req_cmd_in = 4'd1;
        req_data_in = 2;
        drive(0, 3);
        repeat (L) drive(0, 0);
        @(negedge c_clk);
        check("b2b_second", 32'(out_resp), 1, out_data, 5);

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge c_clk);
            reset = ($urandom_range(0, 599) == 0);
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: dv = 32'hFFFF_FFFF;
                1: dv = 0;
                2: dv = $urandom_range(0, 40);
                default: dv = $urandom;
            endcase
            req_data_in = dv;
            if ($urandom_range(0, 2) == 0) req_cmd_in = 4'($urandom_range(0, 15));
            else req_cmd_in = 4'd0;
        end
        @(negedge c_clk);
        reset = 1'b0;
        req_cmd_in = 4'd0;
        repeat (L + 4) drive(0, 0);
        @(negedge c_clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending responses, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
